// File: rtl/seq_restoring_divider_pkg.sv
// Shared arithmetic-library definitions: FSM encodings and default operand width.
package seq_restoring_divider_pkg;

  localparam int DEFAULT_N = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Divider request/response bundle. The master is the issuing controller.
interface seq_restoring_divider_if
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, a, b,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, a, b,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial-subtract.
module seq_restoring_divider_div_step #(
  parameter int N = 16
) (
  input  logic [N-1:0] rem,
  input  logic         in_bit,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_nxt,
  output logic         q_bit
);
  logic [N:0] shifted;
  logic [N:0] trial;

  // The partial remainder is always < divisor, so a non-negative trial and
  // the restored value both fit back into N bits.
  always_comb begin
    shifted = {rem, in_bit};
    trial   = shifted - {1'b0, divisor};
    q_bit   = ~trial[N];
    rem_nxt = trial[N] ? shifted[N-1:0] : trial[N-1:0];
  end
endmodule

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// FIN also accepts a new start so back-to-back ops complete every N+1 cycles.
module seq_restoring_divider
  import seq_restoring_divider_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input logic                   clk,
  input logic                   rst_n,
  seq_restoring_divider_if.slave bus
);
  localparam int CW = $clog2(N);

  state_t        state, state_nxt;
  logic [N-1:0]  rem, q, dvsr;
  logic [N-1:0]  rem_nxt;
  logic          q_bit;
  logic [CW-1:0] cnt;
  logic          dz;
  logic          accept;

  logic          done_r, dz_r;
  logic [N-1:0]  quo_r, rem_r;

  assign accept = bus.start && (state == IDLE || state == FIN);

  seq_restoring_divider_div_step #(.N(N)) u_step (
    .rem     (rem),
    .in_bit  (q[N-1]),
    .divisor (dvsr),
    .rem_nxt (rem_nxt),
    .q_bit   (q_bit)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state: zero divisor skips the iteration and goes straight to FIN
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = (bus.b == '0) ? FIN : RUN;
      RUN:  if (cnt == '0) state_nxt = FIN;
      FIN:  begin
        if (accept) state_nxt = (bus.b == '0) ? FIN : RUN;
        else        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers: load on accept, shift/subtract while running.
  // Divide-by-zero preloads the final answer so FIN just copies it out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem  <= '0;
      q    <= '0;
      dvsr <= '0;
      cnt  <= '0;
      dz   <= 1'b0;
    end else if (accept) begin
      dvsr <= bus.b;
      cnt  <= CW'(N-1);
      if (bus.b == '0) begin
        q   <= '1;
        rem <= bus.a;
        dz  <= 1'b1;
      end else begin
        q   <= bus.a;
        rem <= '0;
        dz  <= 1'b0;
      end
    end else if (state == RUN) begin
      rem <= rem_nxt;
      q   <= {q[N-2:0], q_bit};
      if (cnt != '0) cnt <= cnt - 1'b1;
    end
  end

  // Result registers: updated only on the FIN edge, done pulses one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_r <= 1'b0;
      quo_r  <= '0;
      rem_r  <= '0;
      dz_r   <= 1'b0;
    end else begin
      done_r <= (state == FIN);
      if (state == FIN) begin
        quo_r <= q;
        rem_r <= rem;
        dz_r  <= dz;
      end
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.quotient    = quo_r;
  assign bus.remainder   = rem_r;
  assign bus.div_by_zero = dz_r;
endmodule
